// File: rtl/dogx_power_sequencer.sv
// DOGX power-up sequencer: bandgap -> front-end channels -> converter flush -> run.
// Programmer settings arrive from the SCLK domain and are resynchronised to CLK_24M here.
module dogx_power_sequencer #(
    parameter int unsigned BG_SETTLE_CYC = 24000,
    parameter int unsigned FE_SETTLE_CYC = 2400,
    parameter int unsigned FLUSH_CYC     = 64,
    parameter int unsigned CNT_W         = 16
) (
    input  logic       CLK_24M,
    input  logic       reset,
    input  logic       cfg_dreset,
    input  logic       cfg_hsnr_en,
    input  logic       cfg_hdr_en,
    output logic       bg_on,
    output logic       HSNR_EN,
    output logic       HDR_EN,
    output logic       conv_reset,
    output logic       seq_ready,
    output logic [2:0] seq_state
);

    // state   | meaning
    // OFF     | everything off, converter held in reset
    // BG_WAIT | bandgap on, reference settling
    // FE_WAIT | channels enabled, front end settling
    // FLUSH   | front end settled, converter still held in reset
    // RUN     | converter running on a settled front end
    typedef enum logic [2:0] {
        OFF     = 3'd0,
        BG_WAIT = 3'd1,
        FE_WAIT = 3'd2,
        FLUSH   = 3'd3,
        RUN     = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] BG_TC    = CNT_W'(BG_SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] FE_TC    = CNT_W'(FE_SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] FLUSH_TC = CNT_W'(FLUSH_CYC - 1);

    logic [2:0]       sync1_q;
    logic [2:0]       sync2_q;
    logic             s_dreset;
    logic             s_hsnr;
    logic             s_hdr;
    logic [1:0]       s_en;
    logic             any_en;

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [1:0]       en_lat_q;
    logic [1:0]       en_lat_d;

    logic             bg_on_q;
    logic             bg_on_d;
    logic             hsnr_q;
    logic             hsnr_d;
    logic             hdr_q;
    logic             hdr_d;
    logic             conv_reset_q;
    logic             conv_reset_d;
    logic             ready_q;
    logic             ready_d;

    // Static level settings from SCLK: a plain 2-flop synchroniser per bit is enough.
    always_ff @(posedge CLK_24M or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {cfg_dreset, cfg_hsnr_en, cfg_hdr_en};
            sync2_q <= sync1_q;
        end
    end

    assign {s_dreset, s_hsnr, s_hdr} = sync2_q;
    assign s_en   = {s_hsnr, s_hdr};
    assign any_en = s_hsnr | s_hdr;

    always_comb begin
        state_d  = state_q;
        en_lat_d = en_lat_q;
        cnt_d    = '0;
        if (state_q != OFF && (s_dreset || !any_en)) begin
            state_d = OFF;
        end else begin
            case (state_q)
                OFF: begin
                    if (!s_dreset && any_en) begin
                        state_d  = BG_WAIT;
                        en_lat_d = s_en;
                    end
                end
                BG_WAIT: begin
                    // Enable changes here are picked up by the latch on exit.
                    if (cnt_q == BG_TC) begin
                        state_d  = FE_WAIT;
                        en_lat_d = s_en;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                FE_WAIT: begin
                    if (s_en != en_lat_q) begin
                        en_lat_d = s_en;
                    end else if (cnt_q == FE_TC) begin
                        state_d = FLUSH;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                FLUSH: begin
                    if (s_en != en_lat_q) begin
                        state_d  = FE_WAIT;
                        en_lat_d = s_en;
                    end else if (cnt_q == FLUSH_TC) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    if (s_en != en_lat_q) begin
                        state_d  = FE_WAIT;
                        en_lat_d = s_en;
                    end
                end
                default: state_d = OFF;
            endcase
        end
    end

    // Outputs decode the next state so they move on the same edge as seq_state.
    always_comb begin
        bg_on_d      = (state_d != OFF);
        hsnr_d       = 1'b0;
        hdr_d        = 1'b0;
        conv_reset_d = 1'b1;
        ready_d      = 1'b0;
        case (state_d)
            FE_WAIT, FLUSH: begin
                {hsnr_d, hdr_d} = en_lat_d;
            end
            RUN: begin
                {hsnr_d, hdr_d} = en_lat_d;
                conv_reset_d    = 1'b0;
                ready_d         = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK_24M or posedge reset) begin
        if (reset) begin
            state_q      <= OFF;
            cnt_q        <= '0;
            en_lat_q     <= '0;
            bg_on_q      <= 1'b0;
            hsnr_q       <= 1'b0;
            hdr_q        <= 1'b0;
            conv_reset_q <= 1'b1;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            en_lat_q     <= en_lat_d;
            bg_on_q      <= bg_on_d;
            hsnr_q       <= hsnr_d;
            hdr_q        <= hdr_d;
            conv_reset_q <= conv_reset_d;
            ready_q      <= ready_d;
        end
    end

    assign bg_on      = bg_on_q;
    assign HSNR_EN    = hsnr_q;
    assign HDR_EN     = hdr_q;
    assign conv_reset = conv_reset_q;
    assign seq_ready  = ready_q;
    assign seq_state  = state_q;

endmodule

// File: tb/tb_dogx_power_sequencer.sv
// Bench for dogx_power_sequencer: directed scenarios with exact edge timing plus
// randomized enable/reset activity, all checked against a phase-duration reference model.
module tb_dogx_power_sequencer;

    localparam int BG = 8;
    localparam int FE = 4;
    localparam int FL = 2;

    // {bg_on, HSNR_EN, HDR_EN, conv_reset, seq_ready, seq_state}
    localparam logic [7:0] RESET_VEC = 8'b0001_0000;

    logic       CLK_24M     = 1'b0;
    logic       reset       = 1'b0;
    logic       cfg_dreset  = 1'b0;
    logic       cfg_hsnr_en = 1'b0;
    logic       cfg_hdr_en  = 1'b0;
    logic       bg_on;
    logic       HSNR_EN;
    logic       HDR_EN;
    logic       conv_reset;
    logic       seq_ready;
    logic [2:0] seq_state;

    int n_checks = 0;
    int n_pass   = 0;

    dogx_power_sequencer #(
        .BG_SETTLE_CYC (BG),
        .FE_SETTLE_CYC (FE),
        .FLUSH_CYC     (FL),
        .CNT_W         (16)
    ) dut (
        .CLK_24M     (CLK_24M),
        .reset       (reset),
        .cfg_dreset  (cfg_dreset),
        .cfg_hsnr_en (cfg_hsnr_en),
        .cfg_hdr_en  (cfg_hdr_en),
        .bg_on       (bg_on),
        .HSNR_EN     (HSNR_EN),
        .HDR_EN      (HDR_EN),
        .conv_reset  (conv_reset),
        .seq_ready   (seq_ready),
        .seq_state   (seq_state)
    );

    always #5 CLK_24M = ~CLK_24M;

    wire [7:0] dut_vec = {bg_on, HSNR_EN, HDR_EN, conv_reset, seq_ready, seq_state};

    // Reference model: state number, cycles spent in the current phase, latched enables,
    // and the two-edge visibility delay of the programmer inputs.
    int         m_state = 0;
    int         m_age   = 0;
    logic [1:0] m_lat   = 2'b00;
    logic [2:0] m_p0    = 3'b000;
    logic [2:0] m_p1    = 3'b000;

    function automatic int phase_len(input int st);
        case (st)
            1:       return BG;
            2:       return FE;
            3:       return FL;
            default: return 0;
        endcase
    endfunction

    function automatic logic [7:0] model_vec();
        logic [1:0] en;
        en = (m_state >= 2) ? m_lat : 2'b00;
        return {m_state != 0, en, m_state != 4, m_state == 4, 3'(m_state)};
    endfunction

    always @(posedge CLK_24M or posedge reset) begin : model
        logic       d;
        logic [1:0] en;
        int         nxt;
        bit         entered;
        if (reset) begin
            m_state = 0;
            m_age   = 0;
            m_lat   = 2'b00;
            m_p0    = 3'b000;
            m_p1    = 3'b000;
        end else begin
            d       = m_p1[2];
            en      = m_p1[1:0];
            nxt     = m_state;
            entered = 1'b0;
            if (m_state != 0 && (d || en == 2'b00)) begin
                nxt = 0;
            end else if (m_state == 0) begin
                if (!d && en != 2'b00) begin
                    nxt   = 1;
                    m_lat = en;
                end
            end else if (m_state >= 2 && en != m_lat) begin
                nxt     = 2;
                m_lat   = en;
                entered = 1'b1;
            end else if (m_state <= 3 && m_age + 1 == phase_len(m_state)) begin
                if (m_state == 1) m_lat = en;
                nxt = m_state + 1;
            end
            if (nxt != m_state || entered) m_age = 0;
            else m_age++;
            m_state = nxt;
            m_p1    = m_p0;
            m_p0    = {cfg_dreset, cfg_hsnr_en, cfg_hdr_en};
        end
    end

    task automatic tick();
        @(negedge CLK_24M);
    endtask

    task automatic test_reset();
        cfg_dreset  = 1'($urandom);
        cfg_hsnr_en = 1'($urandom);
        cfg_hdr_en  = 1'($urandom);
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if (dut_vec !== RESET_VEC)
            $display("FAIL reset_async: got %b expected %b", dut_vec, RESET_VEC);
        else n_pass++;
        repeat (2) begin
            tick();
            n_checks++;
            if (dut_vec !== RESET_VEC)
                $display("FAIL reset_held: got %b expected %b", dut_vec, RESET_VEC);
            else n_pass++;
        end
    endtask

    task automatic test_cold_start();
        int exp_st;
        cfg_dreset  = 1'b0;
        cfg_hsnr_en = 1'b0;
        cfg_hdr_en  = 1'b0;
        reset       = 1'b0;
        tick();
        cfg_hsnr_en = 1'b1;
        for (int e = 1; e <= 17; e++) begin
            tick();
            exp_st = (e < 3) ? 0 : (e < 11) ? 1 : (e < 15) ? 2 : (e < 17) ? 3 : 4;
            n_checks++;
            if (seq_state !== 3'(exp_st))
                $display("FAIL cold_state edge %0d: got %0d expected %0d", e, seq_state, exp_st);
            else n_pass++;
            n_checks++;
            if (dut_vec !== model_vec())
                $display("FAIL cold_model edge %0d: got %b expected %b", e, dut_vec, model_vec());
            else n_pass++;
            if (e == 3) begin
                n_checks++;
                if (bg_on !== 1'b1 || HSNR_EN !== 1'b0)
                    $display("FAIL cold_bg_on: got bg=%b hsnr=%b expected bg=1 hsnr=0", bg_on, HSNR_EN);
                else n_pass++;
            end
            if (e == 11) begin
                n_checks++;
                if (HSNR_EN !== 1'b1 || HDR_EN !== 1'b0)
                    $display("FAIL cold_ch_en: got hsnr=%b hdr=%b expected 1 0", HSNR_EN, HDR_EN);
                else n_pass++;
            end
        end
        n_checks++;
        if (dut_vec !== 8'b1100_1100)
            $display("FAIL cold_run: got %b expected %b", dut_vec, 8'b1100_1100);
        else n_pass++;
    endtask

    task automatic test_reconfig();
        int exp_st;
        cfg_hdr_en = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            exp_st = (k < 3) ? 4 : (k < 7) ? 2 : (k < 9) ? 3 : 4;
            n_checks++;
            if (seq_state !== 3'(exp_st))
                $display("FAIL reconfig_state k%0d: got %0d expected %0d", k, seq_state, exp_st);
            else n_pass++;
            n_checks++;
            if (dut_vec !== model_vec())
                $display("FAIL reconfig_model k%0d: got %b expected %b", k, dut_vec, model_vec());
            else n_pass++;
            if (k == 3) begin
                n_checks++;
                if (dut_vec !== 8'b1111_0010)
                    $display("FAIL reconfig_outputs: got %b expected %b", dut_vec, 8'b1111_0010);
                else n_pass++;
            end
        end
    endtask

    task automatic test_dreset_abort();
        int exp_st;
        cfg_hdr_en = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (seq_state !== 3'd2)
            $display("FAIL dreset_setup: got %0d expected 2", seq_state);
        else n_pass++;
        cfg_dreset = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            exp_st = (k < 3) ? 2 : 0;
            n_checks++;
            if (seq_state !== 3'(exp_st))
                $display("FAIL dreset_state k%0d: got %0d expected %0d", k, seq_state, exp_st);
            else n_pass++;
        end
        n_checks++;
        if (dut_vec !== RESET_VEC)
            $display("FAIL dreset_outputs: got %b expected %b", dut_vec, RESET_VEC);
        else n_pass++;
        cfg_dreset = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            tick();
            exp_st = (k < 3) ? 0 : (k < 11) ? 1 : (k < 15) ? 2 : (k < 17) ? 3 : 4;
            n_checks++;
            if (seq_state !== 3'(exp_st))
                $display("FAIL restart_state k%0d: got %0d expected %0d", k, seq_state, exp_st);
            else n_pass++;
            n_checks++;
            if (dut_vec !== model_vec())
                $display("FAIL restart_model k%0d: got %b expected %b", k, dut_vec, model_vec());
            else n_pass++;
            if (k == 11) begin
                n_checks++;
                if (dut_vec !== 8'b1101_0010)
                    $display("FAIL restart_fe: got %b expected %b", dut_vec, 8'b1101_0010);
                else n_pass++;
            end
        end
    endtask

    task automatic test_abort_priority();
        int exp_st;
        cfg_hdr_en = 1'b1;
        repeat (9) tick();
        n_checks++;
        if (seq_state !== 3'd4 || HDR_EN !== 1'b1)
            $display("FAIL abort_setup: got state=%0d hdr=%b expected 4 1", seq_state, HDR_EN);
        else n_pass++;
        // Enables drop to 00 while differing from the latched 11: abort and reconfig coincide.
        cfg_hsnr_en = 1'b0;
        cfg_hdr_en  = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            exp_st = (k < 3) ? 4 : 0;
            n_checks++;
            if (seq_state !== 3'(exp_st))
                $display("FAIL abort_prio k%0d: got %0d expected %0d", k, seq_state, exp_st);
            else n_pass++;
            n_checks++;
            if (dut_vec !== model_vec())
                $display("FAIL abort_model k%0d: got %b expected %b", k, dut_vec, model_vec());
            else n_pass++;
        end
    endtask

    task automatic test_async_reset_mid();
        int exp_st;
        cfg_hsnr_en = 1'b1;
        cfg_hdr_en  = 1'b1;
        repeat (8) tick();
        // Entered BG_WAIT on the 3rd edge, so the phase counter now reads 5.
        n_checks++;
        if (seq_state !== 3'd1)
            $display("FAIL midrst_setup: got %0d expected 1", seq_state);
        else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (dut_vec !== RESET_VEC)
            $display("FAIL midrst_async: got %b expected %b", dut_vec, RESET_VEC);
        else n_pass++;
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp_st = (k < 3) ? 0 : (k < 11) ? 1 : 2;
            n_checks++;
            if (seq_state !== 3'(exp_st))
                $display("FAIL midrst_state k%0d: got %0d expected %0d", k, seq_state, exp_st);
            else n_pass++;
            n_checks++;
            if (dut_vec !== model_vec())
                $display("FAIL midrst_model k%0d: got %b expected %b", k, dut_vec, model_vec());
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 24) == 0) cfg_hsnr_en = ~cfg_hsnr_en;
            if ($urandom_range(0, 24) == 0) cfg_hdr_en  = ~cfg_hdr_en;
            if ($urandom_range(0, 79) == 0) cfg_dreset  = ~cfg_dreset;
            reset = ($urandom_range(0, 299) == 0);
            tick();
            n_checks++;
            if (dut_vec !== model_vec())
                $display("FAIL random_model cyc %0d: got %b expected %b", i, dut_vec, model_vec());
            else n_pass++;
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cold_start();
        test_reconfig();
        test_dreset_abort();
        test_abort_priority();
        test_async_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
